// File: rtl/bram_axil_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and byte-to-word address helper
// for the block-RAM AXI4-Lite slave.
package bram_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_COLLECT,
      W_RESP
   } wstate_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_MEM,
      R_RESP
   } rstate_e;

   // Byte address to 32-bit word index; the two lane-select bits are dropped.
   function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
      return byte_addr >> 2;
   endfunction

endpackage

// File: rtl/bram_sp.sv
// Single-port byte-writable word RAM with registered read data, BRAM-inferable.
// One access per cycle; a read launched at edge k is visible on rdata_o after edge k.
module bram_sp #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [DEPTH];

   // Contents survive reset by design, so no reset term here.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
               mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
         if (we_i == 4'b0000) begin
            rdata_o <= mem[addr_i];
         end
      end
   end

endmodule

// File: rtl/bram_axil_slave.sv
// AXI4-Lite slave over a single-port word RAM: write B one cycle after the last AW/W
// handshake, read R two cycles after AR (+1 per lost port cycle); responses held until READY.
module bram_axil_slave
   import bram_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int C_MEM_DEPTH        = 8
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   localparam int AW     = C_S_AXI_ADDR_WIDTH;
   localparam int DW     = C_S_AXI_DATA_WIDTH;
   localparam int SW     = DW / 8;
   localparam int MEM_AW = (C_MEM_DEPTH > 1) ? $clog2(C_MEM_DEPTH) : 1;

   wstate_e          w_state_q;
   logic             aw_held_q;
   logic             w_held_q;
   logic [AW-1:0]    awaddr_q;
   logic [DW-1:0]    wdata_q;
   logic [SW-1:0]    wstrb_q;
   logic             awready_q;
   logic             wready_q;
   logic             bvalid_q;
   logic [1:0]       bresp_q;

   rstate_e          r_state_q;
   logic [AW-1:0]    araddr_q;
   logic             arready_q;
   logic             rd_issued_q;
   logic             rvalid_q;
   logic [1:0]       rresp_q;
   logic [DW-1:0]    rdata_q;

   logic             aw_hs;
   logic             w_hs;
   logic             wr_commit;
   logic             rd_launch;
   logic [31:0]      aw_idx;
   logic [31:0]      ar_idx;
   logic             aw_in_range;
   logic             ar_in_range;
   logic             mem_en;
   logic [SW-1:0]    mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [DW-1:0]    mem_rdata;
   logic             unused_prot;

   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   assign aw_hs       = S_AXI_AWVALID && awready_q;
   assign w_hs        = S_AXI_WVALID && wready_q;
   assign aw_idx      = word_index(32'(awaddr_q));
   assign ar_idx      = word_index(32'(araddr_q));
   assign aw_in_range = aw_idx < C_MEM_DEPTH;
   assign ar_in_range = ar_idx < C_MEM_DEPTH;

   // Write commit owns the port whenever it fires; the read simply retries next cycle.
   assign wr_commit = (w_state_q == W_COLLECT) && aw_held_q && w_held_q;
   assign rd_launch = (r_state_q == R_MEM) && !rd_issued_q && !wr_commit;

   assign mem_en   = rd_launch || (wr_commit && aw_in_range);
   assign mem_we   = (wr_commit && aw_in_range) ? wstrb_q : '0;
   assign mem_addr = wr_commit ? aw_idx[MEM_AW-1:0] : ar_idx[MEM_AW-1:0];

   bram_sp #(
      .DEPTH (C_MEM_DEPTH),
      .AW    (MEM_AW)
   ) u_bram (
      .clk_i   (ACLK),
      .en_i    (mem_en),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q <= W_COLLECT;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (w_state_q)
            W_COLLECT: begin
               if (aw_hs) begin
                  aw_held_q <= 1'b1;
                  awaddr_q  <= S_AXI_AWADDR;
               end
               if (w_hs) begin
                  w_held_q <= 1'b1;
                  wdata_q  <= S_AXI_WDATA;
                  wstrb_q  <= S_AXI_WSTRB;
               end
               awready_q <= !(aw_held_q || aw_hs);
               wready_q  <= !(w_held_q || w_hs);
               if (wr_commit) begin
                  w_state_q <= W_RESP;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  w_state_q <= W_COLLECT;
                  bvalid_q  <= 1'b0;
                  aw_held_q <= 1'b0;
                  w_held_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: w_state_q <= W_COLLECT;
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state_q   <= R_IDLE;
         araddr_q    <= '0;
         arready_q   <= 1'b0;
         rd_issued_q <= 1'b0;
         rvalid_q    <= 1'b0;
         rresp_q     <= RESP_OKAY;
         rdata_q     <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (S_AXI_ARVALID && arready_q) begin
                  araddr_q    <= S_AXI_ARADDR;
                  arready_q   <= 1'b0;
                  rd_issued_q <= 1'b0;
                  r_state_q   <= R_MEM;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_MEM: begin
               // RAM output is registered, so data is consumed the cycle after launch.
               if (rd_issued_q) begin
                  rd_issued_q <= 1'b0;
                  rvalid_q    <= 1'b1;
                  rdata_q     <= ar_in_range ? mem_rdata : '0;
                  rresp_q     <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                  r_state_q   <= R_RESP;
               end else if (rd_launch) begin
                  rd_issued_q <= 1'b1;
               end
            end
            R_RESP: begin
               if (S_AXI_RREADY) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  r_state_q <= R_IDLE;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_bram_axil_slave.sv
// Directed bench for bram_axil_slave: word-array model with response queues checked
// every cycle, plus literal checks on data, responses, latency and backpressure.
module tb_bram_axil_slave;

   logic        aclk = 1'b0;
   logic        areset;
   logic [5:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [5:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_mem [8];
   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];

   always #5 aclk = ~aclk;

   bram_axil_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (6),
      .C_MEM_DEPTH        (8)
   ) dut (
      .ACLK          (aclk),
      .ARESET        (areset),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready)
   );

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endfunction

   function automatic void check1(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endfunction

   // Model: byte-lane merge into an 8-word array, response decided by word index range.
   function automatic void model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      idx = int'(addr) / 4;
      if (idx < 8) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
         exp_b.push_back(2'b00);
      end else begin
         exp_b.push_back(2'b10);
      end
   endfunction

   function automatic void model_read(input logic [5:0] addr);
      int idx;
      idx = int'(addr) / 4;
      if (idx < 8) exp_r.push_back({model_mem[idx], 2'b00});
      else         exp_r.push_back({32'h0, 2'b10});
   endfunction

   // Every cycle a response is presented it must match the oldest expected one.
   always @(negedge aclk) begin
      if (!areset) begin
         if (bvalid) begin
            check1("bvalid_expected", exp_b.size() != 0, 1'b1);
            if (exp_b.size() != 0) begin
               check("bresp_model", 32'(bresp), 32'(exp_b[0]));
               if (bready) void'(exp_b.pop_front());
            end
         end
         if (rvalid) begin
            check1("rvalid_expected", exp_r.size() != 0, 1'b1);
            if (exp_r.size() != 0) begin
               check("rdata_model", rdata, exp_r[0][33:2]);
               check("rresp_model", 32'(rresp), 32'(exp_r[0][1:0]));
               if (rready) void'(exp_r.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output int lat, output logic [1:0] resp);
      logic a;
      logic w;
      int   guard;
      model_write(addr, data, strb);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      guard = 0;
      while ((awvalid || wvalid) && guard < 20) begin
         a = awvalid && awready;
         w = wvalid && wready;
         tick();
         guard++;
         if (a) awvalid = 1'b0;
         if (w) wvalid = 1'b0;
      end
      check1("write_accept_in_time", guard < 20, 1'b1);
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 0;
      while (!bvalid && lat < 20) begin
         tick();
         lat++;
      end
      resp = bresp;
      tick();
   endtask

   task automatic axi_read(input logic [5:0] addr, output int lat, output logic [31:0] data, output logic [1:0] resp);
      logic done;
      int   guard;
      model_read(addr);
      araddr = addr;
      arvalid = 1'b1;
      done = 1'b0;
      guard = 0;
      while (!done && guard < 20) begin
         done = arready;
         tick();
         guard++;
      end
      arvalid = 1'b0;
      check1("read_accept_in_time", done, 1'b1);
      lat = 0;
      while (!rvalid && lat < 20) begin
         tick();
         lat++;
      end
      data = rdata;
      resp = rresp;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          wl;
      int          rl;
      logic [1:0]  resp;
      logic [31:0] d;
      logic [31:0] rd_col;
      logic [31:0] seq_vals [4];

      for (int i = 0; i < 8; i++) model_mem[i] = 32'h0;
      areset = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;

      // Reset state
      tick(); tick(); tick();
      check1("rst_awready", awready, 1'b0);
      check1("rst_wready", wready, 1'b0);
      check1("rst_arready", arready, 1'b0);
      check1("rst_bvalid", bvalid, 1'b0);
      check1("rst_rvalid", rvalid, 1'b0);
      check("rst_bresp", 32'(bresp), 32'h0);
      check("rst_rresp", 32'(rresp), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      areset = 1'b0;
      check1("pre_edge_awready", awready, 1'b0);
      tick();
      check1("post_rst_awready", awready, 1'b1);
      check1("post_rst_wready", wready, 1'b1);
      check1("post_rst_arready", arready, 1'b1);

      // Sequential write then read-back
      for (int i = 0; i < 4; i++) begin
         axi_write(6'(i * 4), 32'(i + 1), 4'hF, lat, resp);
         check("seq_write_latency", 32'(lat), 32'd1);
         check("seq_bresp", 32'(resp), 32'h0);
      end
      seq_vals[0] = 32'h1; seq_vals[1] = 32'h2; seq_vals[2] = 32'h3; seq_vals[3] = 32'h4;
      for (int i = 0; i < 4; i++) begin
         axi_read(6'(i * 4), lat, d, resp);
         check("seq_read_latency", 32'(lat), 32'd2);
         check("seq_rdata", d, seq_vals[i]);
         check("seq_rresp", 32'(resp), 32'h0);
      end

      // Byte strobes
      axi_write(6'h10, 32'hAABBCCDD, 4'hF, lat, resp);
      axi_write(6'h10, 32'h11223344, 4'h5, lat, resp);
      check("strobe_bresp", 32'(resp), 32'h0);
      axi_read(6'h10, lat, d, resp);
      check("strobe_rdata", d, 32'hAA22CC44);
      check("strobe_model_pin", model_mem[4], 32'hAA22CC44);

      // Out of range
      axi_write(6'h20, 32'hDEADBEEF, 4'hF, lat, resp);
      check("oor_bresp", 32'(resp), 32'h2);
      axi_read(6'h20, lat, d, resp);
      check("oor_rdata", d, 32'h0);
      check("oor_rresp", 32'(resp), 32'h2);
      axi_read(6'h00, lat, d, resp);
      check("oor_word0_kept", d, 32'h1);

      // W ahead of AW, then B held off by the master
      bready = 1'b0;
      model_write(6'h14, 32'h0BADF00D, 4'hF);
      wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      check1("bp_wready_after_w", wready, 1'b0);
      check1("bp_awready_after_w", awready, 1'b1);
      tick(); tick(); tick();
      check1("bp_no_bvalid_without_aw", bvalid, 1'b0);
      awaddr = 6'h14; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check1("bp_bvalid_not_yet", bvalid, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check1("bp_bvalid_held", bvalid, 1'b1);
         check1("bp_awready_low", awready, 1'b0);
         check1("bp_wready_low", wready, 1'b0);
         if (i < 4) tick();
      end
      bready = 1'b1;
      tick();
      check1("bp_bvalid_cleared", bvalid, 1'b0);
      check1("bp_awready_back", awready, 1'b1);
      check1("bp_wready_back", wready, 1'b1);
      axi_read(6'h14, lat, d, resp);
      check("bp_readback", d, 32'h0BADF00D);

      // Write commit and read launch in the same cycle
      model_write(6'h08, 32'h55, 4'hF);
      model_read(6'h08);
      awaddr = 6'h08; wdata = 32'h55; wstrb = 4'hF; araddr = 6'h08;
      check1("col_all_ready", awready && wready && arready, 1'b1);
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      wl = -1; rl = -1; rd_col = 32'hFFFFFFFF;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (bvalid && wl < 0) wl = c;
         if (rvalid && rl < 0) begin
            rl = c;
            rd_col = rdata;
         end
      end
      check("col_write_latency", 32'(wl), 32'd1);
      check("col_read_latency", 32'(rl), 32'd3);
      check("col_rdata", rd_col, 32'h55);
      check("col_model_pin", model_mem[2], 32'h55);

      // Reset with AW held, W missing and a read response pending
      axi_write(6'h18, 32'h66, 4'hF, lat, resp);
      rready = 1'b0;
      model_read(6'h04);
      araddr = 6'h04; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      awaddr = 6'h18; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      check1("rst_mid_rvalid_pending", rvalid, 1'b1);
      areset = 1'b1;
      #1;
      check1("rst_mid_bvalid", bvalid, 1'b0);
      check1("rst_mid_rvalid", rvalid, 1'b0);
      check1("rst_mid_awready", awready, 1'b0);
      exp_b.delete();
      exp_r.delete();
      tick(); tick();
      areset = 1'b0;
      rready = 1'b1;
      tick();
      axi_read(6'h18, lat, d, resp);
      check("rst_mid_word_kept", d, 32'h66);
      check("rst_mid_rresp", 32'(resp), 32'h0);
      tick(); tick();
      check("queues_drained", 32'(exp_b.size() + exp_r.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
